// File: rtl/iq_shift_hop_scheduler.sv
// -----------------------------------------------------------------------------
// iq_shift_hop_scheduler
//
// Frequency-hop scheduler for the IQ frequency-shift datapath. It walks a
// programmable table of (phase increment, dwell) entries and drives the
// shifter's phase-increment input. After each retune it holds data_valid low
// for the shifter's pipeline flush time, then holds the tone for the
// programmed dwell with data_valid high.
//
// Ports:
//   clock          : single rising-edge clock
//   resetn         : asynchronous active-low reset
//   cfg_wr_en      : table write strobe (one entry per cycle, allowed while busy)
//   cfg_wr_addr    : table entry index written
//   cfg_wr_inc     : phase increment for that entry
//   cfg_wr_dwell   : dwell in clocks for that entry (0 behaves as 1)
//   cfg_num_slots  : active entry count, sampled on accepted start (clamped)
//   cfg_loop       : 1 = repeat table forever, sampled on accepted start
//   start          : begin sequence (level-sampled, ignored while busy)
//   stop           : abort sequence (level-sampled, wins over start)
//   dds_phase_inc  : registered phase increment to the shifter
//   data_valid     : shifter output settled on the current tone
//   hop_strobe     : one-cycle pulse coincident with each dds_phase_inc update
//   cur_slot       : table slot currently applied
//   busy           : sequence active
//   done           : one-cycle pulse at normal (non-looping) completion
// -----------------------------------------------------------------------------
module iq_shift_hop_scheduler #(
    parameter int NUM_SLOTS    = 8,
    parameter int DWELL_WIDTH  = 24,
    parameter int FLUSH_CYCLES = 12,
    parameter int SLOT_W       = $clog2(NUM_SLOTS)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   cfg_wr_en,
    input  logic [SLOT_W-1:0]      cfg_wr_addr,
    input  logic [15:0]            cfg_wr_inc,
    input  logic [DWELL_WIDTH-1:0] cfg_wr_dwell,
    input  logic [SLOT_W:0]        cfg_num_slots,
    input  logic                   cfg_loop,
    input  logic                   start,
    input  logic                   stop,
    output logic [15:0]            dds_phase_inc,
    output logic                   data_valid,
    output logic                   hop_strobe,
    output logic [SLOT_W-1:0]      cur_slot,
    output logic                   busy,
    output logic                   done
);

    // The flush counter only ever holds FLUSH_CYCLES-1 down to 0.
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DWELL
    } state_t;

    // Out-of-range slot counts are folded into 1..NUM_SLOTS when latched.
    function automatic logic [SLOT_W:0] clamp_slots(input logic [SLOT_W:0] n);
        if (n == '0)
            return (SLOT_W+1)'(1);
        else if (n > (SLOT_W+1)'(NUM_SLOTS))
            return (SLOT_W+1)'(NUM_SLOTS);
        else
            return n;
    endfunction

    // Counter reload for a dwell of d clocks; a dwell of 0 behaves as 1.
    function automatic logic [DWELL_WIDTH-1:0] dwell_reload(input logic [DWELL_WIDTH-1:0] d);
        if (d == '0)
            return '0;
        else
            return d - DWELL_WIDTH'(1);
    endfunction

    // Hop table
    logic [15:0]            inc_tbl   [NUM_SLOTS];
    logic [DWELL_WIDTH-1:0] dwell_tbl [NUM_SLOTS];

    state_t                 state, state_nxt;
    logic [SLOT_W:0]        num_act, num_act_nxt;
    logic                   loop_en, loop_en_nxt;
    logic [SLOT_W-1:0]      slot, slot_nxt;
    logic [FLUSH_W-1:0]     flush_cnt, flush_cnt_nxt;
    logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_nxt;
    logic [15:0]            inc_nxt;
    logic                   valid_nxt, strobe_nxt, busy_nxt, done_nxt;
    logic [SLOT_W-1:0]      cur_slot_nxt;
    logic                   last_slot;
    logic                   abort;

    // Reads are combinational from the current array contents, so a write to
    // the same entry on the same edge is not seen until the following cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                inc_tbl[i]   <= '0;
                dwell_tbl[i] <= DWELL_WIDTH'(1);
            end
        end else if (cfg_wr_en) begin
            inc_tbl[cfg_wr_addr]   <= cfg_wr_inc;
            dwell_tbl[cfg_wr_addr] <= cfg_wr_dwell;
        end
    end

    assign last_slot = ({1'b0, slot} == (num_act - (SLOT_W+1)'(1)));
    assign abort     = stop && (state != S_IDLE);

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && !stop) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_FLUSH;
            S_FLUSH: if (flush_cnt == '0) state_nxt = S_DWELL;
            S_DWELL: begin
                if (dwell_cnt == '0)
                    state_nxt = (last_slot && !loop_en) ? S_IDLE : S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort)
            state_nxt = S_IDLE;
    end

    // Output / datapath next values
    always_comb begin
        num_act_nxt   = num_act;
        loop_en_nxt   = loop_en;
        slot_nxt      = slot;
        flush_cnt_nxt = flush_cnt;
        dwell_cnt_nxt = dwell_cnt;
        inc_nxt       = dds_phase_inc;
        cur_slot_nxt  = cur_slot;
        valid_nxt     = data_valid;
        busy_nxt      = busy;
        strobe_nxt    = 1'b0;
        done_nxt      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    num_act_nxt = clamp_slots(cfg_num_slots);
                    loop_en_nxt = cfg_loop;
                    slot_nxt    = '0;
                    busy_nxt    = 1'b1;
                end
            end
            S_LOAD: begin
                inc_nxt       = inc_tbl[slot];
                cur_slot_nxt  = slot;
                strobe_nxt    = 1'b1;
                flush_cnt_nxt = FLUSH_LOAD;
            end
            S_FLUSH: begin
                if (flush_cnt == '0) begin
                    valid_nxt     = 1'b1;
                    dwell_cnt_nxt = dwell_reload(dwell_tbl[slot]);
                end else begin
                    flush_cnt_nxt = flush_cnt - FLUSH_W'(1);
                end
            end
            S_DWELL: begin
                if (dwell_cnt == '0) begin
                    valid_nxt = 1'b0;
                    if (!last_slot) begin
                        slot_nxt = slot + SLOT_W'(1);
                    end else if (loop_en) begin
                        slot_nxt = '0;
                    end else begin
                        busy_nxt = 1'b0;
                        done_nxt = 1'b1;
                    end
                end else begin
                    dwell_cnt_nxt = dwell_cnt - DWELL_WIDTH'(1);
                end
            end
            default: ;
        endcase

        // Abort leaves the applied tone and slot where they are.
        if (abort) begin
            inc_nxt      = dds_phase_inc;
            cur_slot_nxt = cur_slot;
            strobe_nxt   = 1'b0;
            valid_nxt    = 1'b0;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            num_act       <= '0;
            loop_en       <= 1'b0;
            slot          <= '0;
            flush_cnt     <= '0;
            dwell_cnt     <= '0;
            dds_phase_inc <= '0;
            cur_slot      <= '0;
            data_valid    <= 1'b0;
            hop_strobe    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            num_act       <= num_act_nxt;
            loop_en       <= loop_en_nxt;
            slot          <= slot_nxt;
            flush_cnt     <= flush_cnt_nxt;
            dwell_cnt     <= dwell_cnt_nxt;
            dds_phase_inc <= inc_nxt;
            cur_slot      <= cur_slot_nxt;
            data_valid    <= valid_nxt;
            hop_strobe    <= strobe_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
        end
    end

endmodule

// File: tb/tb_iq_shift_hop_scheduler.sv
// -----------------------------------------------------------------------------
// tb_iq_shift_hop_scheduler
//
// Self-checking bench for iq_shift_hop_scheduler. Each scenario task pushes
// the expected hop strobes, data_valid windows and done pulses into queues;
// a monitor pops and compares them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_iq_shift_hop_scheduler;

    localparam int NS = 8;
    localparam int DW = 24;
    localparam int F  = 12;
    localparam int SW = 3;

    logic          clock = 1'b0;
    logic          resetn = 1'b1;
    logic          cfg_wr_en = 1'b0;
    logic [SW-1:0] cfg_wr_addr = '0;
    logic [15:0]   cfg_wr_inc = '0;
    logic [DW-1:0] cfg_wr_dwell = '0;
    logic [SW:0]   cfg_num_slots = '0;
    logic          cfg_loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [15:0]   dds_phase_inc;
    logic          data_valid;
    logic          hop_strobe;
    logic [SW-1:0] cur_slot;
    logic          busy;
    logic          done;

    iq_shift_hop_scheduler #(
        .NUM_SLOTS   (NS),
        .DWELL_WIDTH (DW),
        .FLUSH_CYCLES(F)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_inc   (cfg_wr_inc),
        .cfg_wr_dwell (cfg_wr_dwell),
        .cfg_num_slots(cfg_num_slots),
        .cfg_loop     (cfg_loop),
        .start        (start),
        .stop         (stop),
        .dds_phase_inc(dds_phase_inc),
        .data_valid   (data_valid),
        .hop_strobe   (hop_strobe),
        .cur_slot     (cur_slot),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int            cyc;
        logic [15:0]   inc;
        logic [SW-1:0] slot;
    } hop_t;

    typedef struct {
        int rise;
        int len;
    } dv_t;

    hop_t hq[$];
    dv_t  dq[$];
    int   oq[$];

    logic [15:0] mdl_inc   [NS];
    int          mdl_dwell [NS];

    bit   mon_en  = 1'b0;
    logic dv_prev = 1'b0;
    int   dv_rise = 0;
    hop_t mh;
    dv_t  md;
    int   mo;

    // Scoreboard monitor: compares DUT events against queued expectations.
    initial forever begin
        @(negedge clock);
        if (!resetn || !mon_en) begin
            dv_prev = 1'b0;
        end else begin
            if (hop_strobe) begin
                n_tests++;
                if (hq.size() == 0) begin
                    n_fail++;
                    $display("FAIL hop_unexpected: cyc=%0d inc=%h slot=%0d, required no strobe", cyc, dds_phase_inc, cur_slot);
                end else begin
                    mh = hq.pop_front();
                    if (cyc !== mh.cyc || dds_phase_inc !== mh.inc || cur_slot !== mh.slot) begin
                        n_fail++;
                        $display("FAIL hop: got cyc=%0d inc=%h slot=%0d, required cyc=%0d inc=%h slot=%0d",
                                 cyc, dds_phase_inc, cur_slot, mh.cyc, mh.inc, mh.slot);
                    end
                end
            end
            if (data_valid && !dv_prev)
                dv_rise = cyc;
            if (!data_valid && dv_prev) begin
                n_tests++;
                if (dq.size() == 0) begin
                    n_fail++;
                    $display("FAIL valid_unexpected: rise=%0d len=%0d, required no window", dv_rise, cyc - dv_rise);
                end else begin
                    md = dq.pop_front();
                    if (dv_rise !== md.rise || (cyc - dv_rise) !== md.len) begin
                        n_fail++;
                        $display("FAIL valid_window: got rise=%0d len=%0d, required rise=%0d len=%0d",
                                 dv_rise, cyc - dv_rise, md.rise, md.len);
                    end
                end
            end
            if (done) begin
                n_tests++;
                if (oq.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: cyc=%0d, required no done", cyc);
                end else begin
                    mo = oq.pop_front();
                    if (cyc !== mo || busy !== 1'b0 || data_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL done: got cyc=%0d busy=%b valid=%b, required cyc=%0d busy=0 valid=0",
                                 cyc, busy, data_valid, mo);
                    end
                end
            end
            dv_prev = data_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking inside) ----------------

    task automatic wr(input int a, input logic [15:0] inc, input int dw);
        cfg_wr_en    = 1'b1;
        cfg_wr_addr  = SW'(a);
        cfg_wr_inc   = inc;
        cfg_wr_dwell = DW'(dw);
        @(negedge clock);
        cfg_wr_en    = 1'b0;
        mdl_inc[a]   = inc;
        mdl_dwell[a] = dw;
    endtask

    task automatic go(input int n, input bit lp, output int t0);
        cfg_num_slots = (SW+1)'(n);
        cfg_loop      = lp;
        start         = 1'b1;
        t0            = cyc;
        @(negedge clock);
        start         = 1'b0;
    endtask

    // Expected events for a run whose start was driven at negedge cycle t0.
    task automatic plan(input int t0, input int nhops, input int nslots, input bit with_done);
        int cur;
        int s;
        int dw;
        cur = t0 + 2;
        for (int k = 0; k < nhops; k++) begin
            s  = k % nslots;
            dw = (mdl_dwell[s] == 0) ? 1 : mdl_dwell[s];
            hq.push_back('{cur, mdl_inc[s], SW'(s)});
            dq.push_back('{cur + F, dw});
            cur += 1 + F + dw;
        end
        if (with_done)
            oq.push_back(cur - 1);
    endtask

    task automatic wait_drain(input int budget, output int pending);
        for (int i = 0; i < budget; i++) begin
            if (hq.size() == 0 && dq.size() == 0 && oq.size() == 0)
                break;
            @(negedge clock);
        end
        pending = hq.size() + dq.size() + oq.size();
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++)
            @(negedge clock);
    endtask

    task automatic load_basic();
        wr(0, 16'h0100, 4);
        wr(1, 16'h0200, 4);
        wr(2, 16'h0300, 4);
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        for (int i = 0; i < NS; i++) begin
            mdl_inc[i]   = '0;
            mdl_dwell[i] = 1;
        end
        #1 resetn = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({dds_phase_inc, data_valid, hop_strobe, cur_slot, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: inc=%h valid=%b strobe=%b slot=%0d busy=%b done=%b, required all 0",
                     dds_phase_inc, data_valid, hop_strobe, cur_slot, busy, done);
        end
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int t0;
        int pend;
        load_basic();
        go(3, 1'b0, t0);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        plan(t0, 3, 3, 1'b1);
        wait_drain(200, pend);
        n_tests++;
        if (pend != 0 || busy !== 1'b0 || dds_phase_inc !== 16'h0300) begin
            n_fail++;
            $display("FAIL basic_end: pending=%0d busy=%b inc=%h, required pending=0 busy=0 inc=0300",
                     pend, busy, dds_phase_inc);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int pend;
        // Called on the negedge where done is high: start in the next cycle.
        go(2, 1'b0, t0);
        plan(t0, 2, 2, 1'b1);
        repeat (20) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_drain(200, pend);
        n_tests++;
        if (pend != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back: pending=%0d busy=%b, required pending=0 busy=0", pend, busy);
        end
    endtask

    task automatic test_loop_stop();
        int t0;
        int h;
        int pend;
        go(3, 1'b1, t0);
        plan(t0, 3, 3, 1'b0);
        h = t0 + 2 + 3 * (1 + F + 4);
        hq.push_back('{h, 16'h0100, SW'(0)});
        dq.push_back('{h + F, 2});
        wait_until(h + F + 1);
        n_tests++;
        if (cyc != h + F + 1 || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_reach_dwell: cyc=%0d valid=%b, required cyc=%0d valid=1", cyc, data_valid, h + F + 1);
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        n_tests++;
        if (data_valid !== 1'b0 || busy !== 1'b0 || dds_phase_inc !== 16'h0100 || cur_slot !== SW'(0) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_abort: valid=%b busy=%b inc=%h slot=%0d done=%b, required 0 0 0100 0 0",
                     data_valid, busy, dds_phase_inc, cur_slot, done);
        end
        repeat (40) @(negedge clock);
        pend = hq.size() + dq.size() + oq.size();
        n_tests++;
        if (pend != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_quiet: pending=%0d busy=%b, required 0 0", pend, busy);
        end
    endtask

    task automatic test_clamp();
        int t0;
        int pend;
        // dwell 0 behaves as 1
        wr(0, 16'h0111, 0);
        go(1, 1'b0, t0);
        plan(t0, 1, 1, 1'b1);
        wait_drain(100, pend);
        n_tests++;
        if (pend != 0) begin
            n_fail++;
            $display("FAIL clamp_dwell0: pending=%0d, required 0", pend);
        end
        // num_slots 0 behaves as 1
        wr(0, 16'h0222, 3);
        go(0, 1'b0, t0);
        plan(t0, 1, 1, 1'b1);
        wait_drain(100, pend);
        n_tests++;
        if (pend != 0) begin
            n_fail++;
            $display("FAIL clamp_slots0: pending=%0d, required 0", pend);
        end
        // num_slots 15 behaves as NUM_SLOTS
        for (int i = 0; i < NS; i++)
            wr(i, 16'h1000 + 16'(i), 2);
        go(15, 1'b0, t0);
        plan(t0, NS, NS, 1'b1);
        wait_drain(400, pend);
        n_tests++;
        if (pend != 0 || cur_slot !== SW'(NS - 1)) begin
            n_fail++;
            $display("FAIL clamp_slots15: pending=%0d slot=%0d, required 0 %0d", pend, cur_slot, NS - 1);
        end
    endtask

    task automatic test_contention();
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        repeat (30) @(negedge clock);
        n_tests++;
        if (busy !== 1'b0 || hq.size() != 0) begin
            n_fail++;
            $display("FAIL start_stop_same: busy=%b, required busy=0 and no strobe", busy);
        end
    endtask

    task automatic test_live_update();
        int t0;
        int pend;
        load_basic();
        // Write during slot 0 dwell: slot 1 picks up the new value.
        mdl_inc[1] = 16'h0ABC;
        go(3, 1'b0, t0);
        plan(t0, 3, 3, 1'b1);
        wait_until(t0 + 2 + F + 1);
        wr(1, 16'h0ABC, 4);
        wait_drain(200, pend);
        n_tests++;
        if (pend != 0) begin
            n_fail++;
            $display("FAIL live_update: pending=%0d, required 0", pend);
        end
        // Write on the LOAD cycle of slot 1: the old value is applied.
        go(2, 1'b0, t0);
        plan(t0, 2, 2, 1'b1);
        wait_until(t0 + 1 + (1 + F + 4));
        wr(1, 16'h0DEF, 4);
        wait_drain(200, pend);
        n_tests++;
        if (pend != 0) begin
            n_fail++;
            $display("FAIL load_cycle_write: pending=%0d, required 0", pend);
        end
        // The new value is used on the following run.
        go(2, 1'b0, t0);
        plan(t0, 2, 2, 1'b1);
        wait_drain(200, pend);
        n_tests++;
        if (pend != 0 || dds_phase_inc !== 16'h0DEF) begin
            n_fail++;
            $display("FAIL load_cycle_after: pending=%0d inc=%h, required 0 0DEF", pend, dds_phase_inc);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        int pend;
        load_basic();
        go(3, 1'b0, t0);
        hq.push_back('{t0 + 2, 16'h0100, SW'(0)});
        wait_until(t0 + 2 + F + 1);
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if ({dds_phase_inc, data_valid, hop_strobe, cur_slot, busy, done} !== '0 || hq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_async: inc=%h valid=%b strobe=%b slot=%0d busy=%b done=%b, required all 0",
                     dds_phase_inc, data_valid, hop_strobe, cur_slot, busy, done);
        end
        hq.delete();
        dq.delete();
        oq.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < NS; i++) begin
            mdl_inc[i]   = '0;
            mdl_dwell[i] = 1;
        end
        @(negedge clock);
        go(2, 1'b0, t0);
        plan(t0, 2, 2, 1'b1);
        wait_drain(100, pend);
        n_tests++;
        if (pend != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_restart: pending=%0d busy=%b, required 0 0", pend, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_loop_stop();
        test_clamp();
        test_contention();
        test_live_update();
        test_reset_mid();
        repeat (5) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
